// File: rtl/eth_rx_dispatch_pkg.sv
// Shared constants for the Ethernet receive dispatcher: ethertypes, broadcast MAC,
// header geometry, FSM encoding and a MAC byte-select helper.
package eth_rx_dispatch_pkg;

    localparam logic [15:0] ETYPE_IPV4   = 16'h0800;
    localparam logic [15:0] ETYPE_ARP    = 16'h0806;
    localparam logic [47:0] MAC_BCAST    = 48'hFFFF_FFFF_FFFF;
    localparam logic [3:0]  HDR_LEN      = 4'd14;
    localparam logic [3:0]  HDR_LAST_IDX = 4'd13;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_HDR     = 3'd1;
    localparam logic [2:0] ST_IP_PAY  = 3'd2;
    localparam logic [2:0] ST_ARP_PAY = 3'd3;
    localparam logic [2:0] ST_DROP    = 3'd4;

    // Byte idx of a MAC in wire order: idx 0 is the most significant octet.
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = mac[47:40];
            3'd1:    b = mac[39:32];
            3'd2:    b = mac[31:24];
            3'd3:    b = mac[23:16];
            3'd4:    b = mac[15:8];
            3'd5:    b = mac[7:0];
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/eth_rx_dispatch_hdr_match.sv
// Header parser: destination-MAC filter against a per-frame snapshot, source-MAC
// capture and ethertype assembly. ETH_RX_PROMISC_EN bypasses the destination filter.
module eth_hdr_match
    import eth_rx_dispatch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_byte_en,
    input  logic [3:0]  i_idx,
    input  logic [7:0]  i_data,
    input  logic [47:0] i_local_mac,
    output logic        o_dest_ok,
    output logic [47:0] o_src_mac,
    output logic [15:0] o_ethertype
);

    logic [47:0] snap_d, snap_q;
    logic        uc_match_d, uc_match_q;
    logic        bc_match_d, bc_match_q;
    logic [47:0] src_d, src_q;
    logic [7:0]  type_hi_d, type_hi_q;

    // Per-byte header field capture; byte 0 compares against the live register
    // because the snapshot is only being taken on that same edge.
    always_comb begin
        snap_d     = snap_q;
        uc_match_d = uc_match_q;
        bc_match_d = bc_match_q;
        src_d      = src_q;
        type_hi_d  = type_hi_q;
        if (i_byte_en) begin
            case (i_idx)
                4'd0: begin
                    snap_d     = i_local_mac;
                    uc_match_d = (i_data == i_local_mac[47:40]);
                    bc_match_d = (i_data == MAC_BCAST[47:40]);
                end
                4'd1, 4'd2, 4'd3, 4'd4, 4'd5: begin
                    uc_match_d = uc_match_q && (i_data == mac_byte(snap_q, i_idx[2:0]));
                    bc_match_d = bc_match_q && (i_data == mac_byte(MAC_BCAST, i_idx[2:0]));
                end
                4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11: begin
                    src_d = {src_q[39:0], i_data};
                end
                4'd12: begin
                    type_hi_d = i_data;
                end
                default: begin
                    type_hi_d = type_hi_q;
                end
            endcase
        end else begin
            src_d = src_q;
        end
    end

    // Header field registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            snap_q     <= 48'h0000_0000_0000;
            uc_match_q <= 1'b0;
            bc_match_q <= 1'b0;
            src_q      <= 48'h0000_0000_0000;
            type_hi_q  <= 8'h00;
        end else begin
            snap_q     <= snap_d;
            uc_match_q <= uc_match_d;
            bc_match_q <= bc_match_d;
            src_q      <= src_d;
            type_hi_q  <= type_hi_d;
        end
    end

`ifdef ETH_RX_PROMISC_EN
    assign o_dest_ok = 1'b1;
`else
    assign o_dest_ok = uc_match_q || bc_match_q;
`endif
    assign o_src_mac   = src_q;
    assign o_ethertype = {type_hi_q, i_data};

endmodule

// File: rtl/eth_rx_dispatch.sv
// Ethernet receive dispatcher: filters on destination MAC and routes IPv4/ARP payload
// to dedicated registered streams. Define ETH_RX_PROMISC_EN to accept every destination.
module eth_rx_dispatch
    import eth_rx_dispatch_pkg::*;
#(
    parameter logic [47:0] P_SRC_MAC = 48'h000000000000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [47:0] i_local_mac,
    input  logic        i_local_mac_valid,
    input  logic [7:0]  i_data,
    input  logic        i_valid,
    input  logic        i_last,
    output logic [7:0]  o_ip_data,
    output logic        o_ip_valid,
    output logic        o_ip_last,
    output logic [7:0]  o_arp_data,
    output logic        o_arp_valid,
    output logic        o_arp_last,
    output logic [47:0] o_recv_src_mac,
    output logic        o_recv_src_mac_valid,
    output logic        o_drop
);

    logic [2:0]  state_d, state_q;
    logic [3:0]  cnt_d, cnt_q;
    logic [47:0] local_mac_d, local_mac_q;
    logic [7:0]  ip_data_d, ip_data_q, arp_data_d, arp_data_q;
    logic        ip_valid_d, ip_valid_q, ip_last_d, ip_last_q;
    logic        arp_valid_d, arp_valid_q, arp_last_d, arp_last_q;
    logic [47:0] src_mac_d, src_mac_q;
    logic        src_valid_d, src_valid_q;
    logic        drop_d, drop_q;

    logic        hdr_en_s;
    logic [3:0]  hdr_idx_s;
    logic [3:0]  cnt_inc_s;
    logic        dest_ok_s;
    logic [47:0] hdr_src_s;
    logic [15:0] ethertype_s;

    eth_hdr_match u_hdr_match (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_byte_en   (hdr_en_s),
        .i_idx       (hdr_idx_s),
        .i_data      (i_data),
        .i_local_mac (local_mac_q),
        .o_dest_ok   (dest_ok_s),
        .o_src_mac   (hdr_src_s),
        .o_ethertype (ethertype_s)
    );

    // Frame FSM, byte counter and next-state of all registered outputs.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        src_mac_d   = src_mac_q;
        src_valid_d = 1'b0;
        drop_d      = 1'b0;
        ip_data_d   = 8'h00;
        ip_valid_d  = 1'b0;
        ip_last_d   = 1'b0;
        arp_data_d  = 8'h00;
        arp_valid_d = 1'b0;
        arp_last_d  = 1'b0;
        hdr_en_s    = 1'b0;
        hdr_idx_s   = cnt_q;
        cnt_inc_s   = (cnt_q >= HDR_LEN) ? HDR_LEN : (cnt_q + 4'd1);

        if (i_local_mac_valid) begin
            local_mac_d = i_local_mac;
        end else begin
            local_mac_d = local_mac_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    hdr_en_s  = 1'b1;
                    hdr_idx_s = 4'd0;
                    if (i_last) begin
                        cnt_d  = 4'd0;
                        drop_d = 1'b1;
                    end else begin
                        cnt_d   = 4'd1;
                        state_d = ST_HDR;
                    end
                end else begin
                    cnt_d = 4'd0;
                end
            end
            ST_HDR: begin
                if (!i_valid || i_last) begin
                    // Runt or stalled header: the frame can never be routed.
                    hdr_en_s = i_valid;
                    state_d  = ST_IDLE;
                    cnt_d    = 4'd0;
                    drop_d   = 1'b1;
                end else begin
                    hdr_en_s = 1'b1;
                    cnt_d    = cnt_inc_s;
                    if (cnt_q == HDR_LAST_IDX) begin
                        if (dest_ok_s && (ethertype_s == ETYPE_IPV4)) begin
                            state_d     = ST_IP_PAY;
                            src_mac_d   = hdr_src_s;
                            src_valid_d = 1'b1;
                        end else if (dest_ok_s && (ethertype_s == ETYPE_ARP)) begin
                            state_d     = ST_ARP_PAY;
                            src_mac_d   = hdr_src_s;
                            src_valid_d = 1'b1;
                        end else begin
                            state_d = ST_DROP;
                        end
                    end else begin
                        state_d = ST_HDR;
                    end
                end
            end
            ST_IP_PAY, ST_ARP_PAY: begin
                if (i_valid) begin
                    cnt_d = cnt_inc_s;
                    if (state_q == ST_IP_PAY) begin
                        ip_data_d  = i_data;
                        ip_valid_d = 1'b1;
                        ip_last_d  = i_last;
                    end else begin
                        arp_data_d  = i_data;
                        arp_valid_d = 1'b1;
                        arp_last_d  = i_last;
                    end
                    if (i_last) begin
                        state_d = ST_IDLE;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = state_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    drop_d  = 1'b1;
                end
            end
            ST_DROP: begin
                if (!i_valid || i_last) begin
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                    drop_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // State, local MAC and output registers.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            local_mac_q <= P_SRC_MAC;
            ip_data_q   <= 8'h00;
            ip_valid_q  <= 1'b0;
            ip_last_q   <= 1'b0;
            arp_data_q  <= 8'h00;
            arp_valid_q <= 1'b0;
            arp_last_q  <= 1'b0;
            src_mac_q   <= 48'h0000_0000_0000;
            src_valid_q <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            local_mac_q <= local_mac_d;
            ip_data_q   <= ip_data_d;
            ip_valid_q  <= ip_valid_d;
            ip_last_q   <= ip_last_d;
            arp_data_q  <= arp_data_d;
            arp_valid_q <= arp_valid_d;
            arp_last_q  <= arp_last_d;
            src_mac_q   <= src_mac_d;
            src_valid_q <= src_valid_d;
            drop_q      <= drop_d;
        end
    end

    assign o_ip_data            = ip_data_q;
    assign o_ip_valid           = ip_valid_q;
    assign o_ip_last            = ip_last_q;
    assign o_arp_data           = arp_data_q;
    assign o_arp_valid          = arp_valid_q;
    assign o_arp_last           = arp_last_q;
    assign o_recv_src_mac       = src_mac_q;
    assign o_recv_src_mac_valid = src_valid_q;
    assign o_drop               = drop_q;

endmodule

// File: tb/tb_eth_rx_dispatch.sv
// Self-checking bench for eth_rx_dispatch: directed and random frames against a
// frame-level reference model with cycle-accurate expected output timelines.
module tb_eth_rx_dispatch;

    localparam logic [47:0] P_MAC = 48'h000A_3501_0203;
`ifdef ETH_RX_PROMISC_EN
    localparam bit PROMISC = 1'b1;
`else
    localparam bit PROMISC = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [47:0] i_local_mac = 48'h0;
    logic        i_local_mac_valid = 1'b0;
    logic [7:0]  i_data = 8'h00;
    logic        i_valid = 1'b0;
    logic        i_last = 1'b0;
    logic [7:0]  o_ip_data, o_arp_data;
    logic        o_ip_valid, o_ip_last, o_arp_valid, o_arp_last;
    logic [47:0] o_recv_src_mac;
    logic        o_recv_src_mac_valid, o_drop;

    eth_rx_dispatch #(.P_SRC_MAC(P_MAC)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_local_mac(i_local_mac), .i_local_mac_valid(i_local_mac_valid),
        .i_data(i_data), .i_valid(i_valid), .i_last(i_last),
        .o_ip_data(o_ip_data), .o_ip_valid(o_ip_valid), .o_ip_last(o_ip_last),
        .o_arp_data(o_arp_data), .o_arp_valid(o_arp_valid), .o_arp_last(o_arp_last),
        .o_recv_src_mac(o_recv_src_mac), .o_recv_src_mac_valid(o_recv_src_mac_valid),
        .o_drop(o_drop)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed { logic [31:0] cyc; logic [7:0] data; logic last; } beat_t;
    typedef struct packed { logic [31:0] cyc; logic [47:0] mac; } smac_t;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          idle_bad = 0;
    logic [47:0] model_mac = P_MAC;
    logic [7:0]  frm[$];
    beat_t       exp_ip[$], obs_ip[$], exp_arp[$], obs_arp[$];
    smac_t       exp_src[$], obs_src[$];
    logic [31:0] exp_drop[$], obs_drop[$];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitor: timestamps every beat/strobe with the current cycle.
    beat_t mb;
    smac_t ms;
    always @(negedge i_clk) begin
        mb.cyc = cyc;
        ms.cyc = cyc;
        if (o_ip_valid) begin
            mb.data = o_ip_data; mb.last = o_ip_last; obs_ip.push_back(mb);
        end else if (o_ip_data !== 8'h00 || o_ip_last !== 1'b0) idle_bad++;
        if (o_arp_valid) begin
            mb.data = o_arp_data; mb.last = o_arp_last; obs_arp.push_back(mb);
        end else if (o_arp_data !== 8'h00 || o_arp_last !== 1'b0) idle_bad++;
        if (o_drop) obs_drop.push_back(cyc);
        if (o_recv_src_mac_valid) begin
            ms.mac = o_recv_src_mac; obs_src.push_back(ms);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[47:0];
    endfunction

    task automatic mk_frame(input logic [47:0] dest, input logic [47:0] src,
                            input logic [15:0] et, input int plen, input bit incr);
        frm.delete();
        for (int i = 0; i < 6; i++) frm.push_back(dest[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) frm.push_back(src[47-8*i -: 8]);
        frm.push_back(et[15:8]);
        frm.push_back(et[7:0]);
        for (int i = 0; i < plen; i++) frm.push_back(incr ? 8'(i) : 8'($urandom));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b0; i_last = 1'b0; i_data = 8'h00; i_local_mac_valid = 1'b0;
        end
    endtask

    task automatic load_mac(input logic [47:0] m);
        @(posedge i_clk); #1;
        i_valid = 1'b0; i_last = 1'b0;
        i_local_mac = m; i_local_mac_valid = 1'b1;
        @(posedge i_clk); #1;
        i_local_mac_valid = 1'b0;
        model_mac = m;
    endtask

    // Drives frm contiguously and appends the expected timeline for it.
    task automatic send_frame(input int load_at, input logic [47:0] new_mac, input bit abort);
        int          n, c0, last_c;
        logic [47:0] dest, src, lsnap;
        logic [15:0] et;
        bit          ok, routed, to_ip;
        beat_t       b;
        smac_t       s;
        n = frm.size();
        lsnap = model_mac;
        c0 = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge i_clk); #1;
            if (i == 0) c0 = cyc;
            i_valid = 1'b1;
            i_data = frm[i];
            i_last = (i == n - 1) && !abort;
            i_local_mac_valid = (i == load_at);
            if (i == load_at) i_local_mac = new_mac;
        end
        if (load_at >= 0) model_mac = new_mac;
        last_c = c0 + n - 1;
        dest = 48'h0; src = 48'h0; et = 16'h0;
        for (int i = 0; i < 6 && i < n; i++) dest = {dest[39:0], frm[i]};
        for (int i = 6; i < 12 && i < n; i++) src = {src[39:0], frm[i]};
        if (n >= 14) et = {frm[12], frm[13]};
        ok = PROMISC || dest == lsnap || dest == 48'hFFFF_FFFF_FFFF;
        to_ip = (et == 16'h0800);
        routed = ok && (et == 16'h0800 || et == 16'h0806) && (n > 14 || (abort && n == 14));
        if (routed) begin
            s.cyc = c0 + 14; s.mac = src; exp_src.push_back(s);
            for (int i = 14; i < n; i++) begin
                b.cyc = c0 + i + 1; b.data = frm[i]; b.last = !abort && (i == n - 1);
                if (to_ip) exp_ip.push_back(b); else exp_arp.push_back(b);
            end
            if (abort) exp_drop.push_back(last_c + 2);
        end else begin
            exp_drop.push_back(abort ? last_c + 2 : last_c + 1);
        end
    endtask

    task automatic clear_all();
        exp_ip.delete(); obs_ip.delete(); exp_arp.delete(); obs_arp.delete();
        exp_src.delete(); obs_src.delete(); exp_drop.delete(); obs_drop.delete();
        idle_bad = 0;
    endtask

    task automatic check_all(input string tag);
        idle(4);
        chk({tag, "/ip_count"}, 64'(obs_ip.size()), 64'(exp_ip.size()));
        for (int i = 0; i < obs_ip.size() && i < exp_ip.size(); i++) begin
            chk({tag, "/ip_cycle"}, 64'(obs_ip[i].cyc), 64'(exp_ip[i].cyc));
            chk({tag, "/ip_data_last"}, 64'({obs_ip[i].data, obs_ip[i].last}),
                64'({exp_ip[i].data, exp_ip[i].last}));
        end
        chk({tag, "/arp_count"}, 64'(obs_arp.size()), 64'(exp_arp.size()));
        for (int i = 0; i < obs_arp.size() && i < exp_arp.size(); i++) begin
            chk({tag, "/arp_cycle"}, 64'(obs_arp[i].cyc), 64'(exp_arp[i].cyc));
            chk({tag, "/arp_data_last"}, 64'({obs_arp[i].data, obs_arp[i].last}),
                64'({exp_arp[i].data, exp_arp[i].last}));
        end
        chk({tag, "/src_count"}, 64'(obs_src.size()), 64'(exp_src.size()));
        for (int i = 0; i < obs_src.size() && i < exp_src.size(); i++) begin
            chk({tag, "/src_cycle"}, 64'(obs_src[i].cyc), 64'(exp_src[i].cyc));
            chk({tag, "/src_mac"}, 64'(obs_src[i].mac), 64'(exp_src[i].mac));
        end
        chk({tag, "/drop_count"}, 64'(obs_drop.size()), 64'(exp_drop.size()));
        for (int i = 0; i < obs_drop.size() && i < exp_drop.size(); i++)
            chk({tag, "/drop_cycle"}, 64'(obs_drop[i]), 64'(exp_drop[i]));
        chk({tag, "/idle_port_zero"}, 64'(idle_bad), 64'd0);
        clear_all();
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "/ip"}, 64'({o_ip_data, o_ip_valid, o_ip_last}), 64'd0);
        chk({tag, "/arp"}, 64'({o_arp_data, o_arp_valid, o_arp_last}), 64'd0);
        chk({tag, "/src_mac"}, 64'(o_recv_src_mac), 64'd0);
        chk({tag, "/src_valid"}, 64'(o_recv_src_mac_valid), 64'd0);
        chk({tag, "/drop"}, 64'(o_drop), 64'd0);
    endtask

    logic [47:0] mac_b, dst, sm;
    logic [15:0] et_r;
    int          kind, plen;

    initial begin
        repeat (3) @(posedge i_clk);
        #1 chk_outputs_zero("reset");
        i_rst = 1'b1;
        idle(2);
        clear_all();

        // Frame to the parameter MAC, 20-byte IPv4 payload 0x00..0x13.
        sm = 48'h0011_2233_4455;
        mk_frame(P_MAC, sm, 16'h0800, 20, 1'b1);
        send_frame(-1, 48'h0, 1'b0);
        check_all("ip_basic");

        mk_frame(48'hFFFF_FFFF_FFFF, rnd48(), 16'h0806, 28, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        check_all("arp_bcast");

        mk_frame(48'h000A_3501_0204, rnd48(), 16'h0800, 12, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        check_all("dest_miss");

        mk_frame(P_MAC, rnd48(), 16'h86DD, 40, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        check_all("type_ipv6");

        mk_frame(P_MAC, rnd48(), 16'h0800, 0, 1'b0);
        while (frm.size() > 10) void'(frm.pop_back());
        send_frame(-1, 48'h0, 1'b0);
        mk_frame(P_MAC, rnd48(), 16'h0800, 0, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        check_all("runt");

        // Runtime MAC: new address accepted, old address rejected.
        mac_b = 48'h0200_0000_BEEF;
        load_mac(mac_b);
        mk_frame(mac_b, rnd48(), 16'h0800, 5, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        mk_frame(P_MAC, rnd48(), 16'h0800, 5, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        check_all("mac_load");

        // A load during byte 2 must not disturb the frame already in progress.
        mk_frame(mac_b, rnd48(), 16'h0806, 6, 1'b0);
        send_frame(2, P_MAC, 1'b0);
        mk_frame(P_MAC, rnd48(), 16'h0806, 6, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        check_all("mac_load_midframe");

        mk_frame(P_MAC, rnd48(), 16'h0800, 9, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        mk_frame(48'hFFFF_FFFF_FFFF, rnd48(), 16'h0806, 28, 1'b0);
        send_frame(-1, 48'h0, 1'b0);
        check_all("back_to_back");

        mk_frame(P_MAC, rnd48(), 16'h0800, 6, 1'b0);
        send_frame(-1, 48'h0, 1'b1);
        idle(1);
        mk_frame(P_MAC, rnd48(), 16'h0800, 0, 1'b0);
        while (frm.size() > 8) void'(frm.pop_back());
        send_frame(-1, 48'h0, 1'b1);
        check_all("abort");

        for (int f = 0; f < 30; f++) begin
            kind = $urandom_range(0, 3);
            case (kind)
                0: dst = model_mac;
                1: dst = 48'hFFFF_FFFF_FFFF;
                2: dst = rnd48();
                default: dst = model_mac ^ (48'h1 << $urandom_range(0, 47));
            endcase
            case ($urandom_range(0, 3))
                0: et_r = 16'h0800;
                1: et_r = 16'h0806;
                2: et_r = 16'h86DD;
                default: et_r = 16'(1 << $urandom_range(0, 15)) ^ 16'h0800;
            endcase
            plen = $urandom_range(1, 20);
            mk_frame(dst, rnd48(), et_r, plen, 1'b0);
            if ($urandom_range(0, 4) == 0)
                while (frm.size() > $urandom_range(1, 13)) void'(frm.pop_back());
            send_frame(-1, 48'h0, 1'b0);
            idle($urandom_range(0, 2));
        end
        check_all("random");

        // Reset asserted while payload byte 5 is on the input.
        mk_frame(P_MAC, rnd48(), 16'h0800, 10, 1'b1);
        for (int i = 0; i < 19; i++) begin
            @(posedge i_clk); #1;
            i_valid = 1'b1; i_data = frm[i]; i_last = 1'b0;
        end
        @(posedge i_clk); #1;
        i_data = frm[19];
        i_rst = 1'b0;
        #1 chk_outputs_zero("reset_midframe");
        i_valid = 1'b0;
        idle(2);
        clear_all();
        i_rst = 1'b1;
        model_mac = P_MAC;
        mk_frame(P_MAC, rnd48(), 16'h0800, 7, 1'b1);
        send_frame(-1, 48'h0, 1'b0);
        check_all("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_rx_dispatch.md
ETH_RX_DISPATCH -- requirements
Module: eth_rx_dispatch

Interface
REQ-001 SHALL have parameter P_SRC_MAC, default 48'h000000000000, local MAC used after reset.
REQ-002 SHALL have i_clk  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have i_rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have i_local_mac  input  48  runtime local MAC; i_local_mac_valid  input  1  load strobe.
REQ-005 SHALL have i_data  input  8, i_valid  input  1, i_last  input  1: frame bytes from dest MAC through payload, FCS/preamble removed, contiguous valid.
REQ-006 SHALL have o_ip_data  output  8, o_ip_valid  output  1, o_ip_last  output  1: IPv4 payload stream.
REQ-007 SHALL have o_arp_data  output  8, o_arp_valid  output  1, o_arp_last  output  1: ARP payload stream.
REQ-008 SHALL have o_recv_src_mac  output  48, o_recv_src_mac_valid  output  1: sender MAC of accepted frame, one-cycle strobe.
REQ-009 SHALL have o_drop  output  1: one-cycle pulse per discarded frame.

Function
REQ-010 SHALL run FSM IDLE, HDR, IP_PAY, ARP_PAY, DROP; byte counter 4 bits, saturating at 14.
REQ-011 IDLE->HDR on i_valid; that byte is index 0; counter increments per valid byte.
REQ-012 Bytes 0-5 SHALL be compared MSB-first to the local-MAC snapshot taken at byte 0; match flag clears on first mismatch.
REQ-013 Dest MAC SHALL be accepted if equal to snapshot or 48'hFFFFFFFFFFFF.
REQ-014 Bytes 6-11 SHALL shift into a source-MAC register; bytes 12-13 form ethertype, big-endian.
REQ-015 At byte 13: accepted and type 16'h0800 -> IP_PAY; accepted and 16'h0806 -> ARP_PAY; otherwise DROP.
REQ-016 On IP_PAY/ARP_PAY entry, o_recv_src_mac SHALL update and o_recv_src_mac_valid pulse one cycle after byte 13 is sampled.
REQ-017 Payload bytes SHALL appear on the selected port exactly one cycle after input, data/valid/last registered; other port stays 0.
REQ-018 o_*_last SHALL mirror i_last of the final payload byte; FSM returns to IDLE on that cycle's edge, accepting a new frame next cycle.
REQ-019 i_last at byte index <=13 SHALL return to IDLE, emit no payload, pulse o_drop one cycle later.
REQ-020 DROP SHALL consume bytes until i_last, then pulse o_drop and return IDLE.
REQ-021 i_valid low mid-frame without i_last SHALL abort to IDLE; no o_*_last emitted; o_drop pulses.
REQ-022 i_local_mac_valid SHALL load the local-MAC register at any time; a load during a frame affects only later frames.

Reset
REQ-023 On i_rst low: FSM IDLE, counter 0, local MAC = P_SRC_MAC, all outputs 0.
REQ-024 Reset mid-frame SHALL discard the frame; after release the first i_valid is byte 0.

Configuration
REQ-025 With ETH_RX_PROMISC_EN defined, dest-MAC check SHALL be bypassed (every dest accepted); ethertype routing unchanged.
REQ-026 Without ETH_RX_PROMISC_EN, REQ-012/013 filtering SHALL apply.

Structure
REQ-027 Shared package SHALL hold ethertype constants (0x0800, 0x0806), broadcast MAC, header length 14, FSM state encoding.
REQ-028 One sub-module eth_hdr_match (dest-MAC compare + ethertype capture) is natural; FSM and output registers stay in top.

Verification
REQ-029 Local MAC 00:0A:35:01:02:03, frame to that MAC, type 0800, 20-byte payload 0x00..0x13 -> o_ip_valid 20 cycles, data 0x00..0x13, o_ip_last on 0x13, src MAC strobe once.
REQ-030 Broadcast ARP frame, 28-byte payload -> 28 bytes on ARP port, IP port idle, no o_drop.
REQ-031 Dest 00:0A:35:01:02:04, type 0800 -> no output valid, o_drop one pulse after last; with ETH_RX_PROMISC_EN -> delivered on IP port.
REQ-032 Type 86DD, 40-byte payload -> dropped, o_drop pulse; 10-byte runt frame -> dropped, o_drop pulse.
REQ-033 Two back-to-back frames (IP then ARP, zero idle gap) -> both delivered intact, correct ports, two src-MAC strobes.
REQ-034 i_rst low at payload byte 5 -> all outputs 0 immediately; next frame after release delivered correctly.
